// File: rtl/array_heap_pkg.sv
// array_heap shared definitions: action codes, error codes, FSM states.
// Action numbering follows the test-program harness.
package array_heap_pkg;

    localparam logic [7:0] A_RESET     = 8'd1;
    localparam logic [7:0] A_WRITE     = 8'd2;
    localparam logic [7:0] A_READ      = 8'd3;
    localparam logic [7:0] A_SIZE      = 8'd4;
    localparam logic [7:0] A_INC       = 8'd5;
    localparam logic [7:0] A_DEC       = 8'd6;
    localparam logic [7:0] A_INDEX     = 8'd7;
    localparam logic [7:0] A_LESS      = 8'd8;
    localparam logic [7:0] A_GREATER   = 8'd9;
    localparam logic [7:0] A_PUSH      = 8'd14;
    localparam logic [7:0] A_POP       = 8'd15;
    localparam logic [7:0] A_RESIZE    = 8'd17;
    localparam logic [7:0] A_ALLOC     = 8'd18;
    localparam logic [7:0] A_FREE      = 8'd19;
    localparam logic [7:0] A_ADD       = 8'd20;
    localparam logic [7:0] A_ADDAFTER  = 8'd21;
    localparam logic [7:0] A_SUB       = 8'd22;
    localparam logic [7:0] A_SUBAFTER  = 8'd23;

    localparam logic [31:0] E_OK      = 32'd0;
    localparam logic [31:0] E_UNALLOC = 32'd1;
    localparam logic [31:0] E_INDEX   = 32'd2;
    localparam logic [31:0] E_FULL    = 32'd3;
    localparam logic [31:0] E_EMPTY   = 32'd4;
    localparam logic [31:0] E_NOSPACE = 32'd5;
    localparam logic [31:0] E_DFREE   = 32'd6;
    localparam logic [31:0] E_RESIZE  = 32'd7;
    localparam logic [31:0] E_ACTION  = 32'd8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_SWEEP,
        ST_RESP
    } state_t;

    function automatic logic is_scan(input logic [7:0] a);
        return (a == A_INDEX) || (a == A_LESS) || (a == A_GREATER);
    endfunction

    function automatic logic is_known(input logic [7:0] a);
        case (a)
            A_RESET, A_WRITE, A_READ, A_SIZE, A_INC, A_DEC,
            A_INDEX, A_LESS, A_GREATER, A_PUSH, A_POP,
            A_RESIZE, A_ALLOC, A_FREE, A_ADD, A_ADDAFTER,
            A_SUB, A_SUBAFTER: return 1'b1;
            default:           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/array_heap_if.sv
// Request/response bundle between the program sequencer and array_heap.
interface array_heap_if #(
    parameter int ADDRESS_BITS = 8,
    parameter int INDEX_BITS   = 3,
    parameter int DATA_BITS    = 16
);
    logic                    reqValid;
    logic                    reqReady;
    logic [7:0]              action;
    logic [ADDRESS_BITS-1:0] array;
    logic [INDEX_BITS-1:0]   index;
    logic [DATA_BITS-1:0]    in;
    logic                    respValid;
    logic [DATA_BITS-1:0]    out;
    logic [31:0]             error;

    modport master (
        output reqValid, action, array, index, in,
        input  reqReady, respValid, out, error
    );

    modport slave (
        input  reqValid, action, array, index, in,
        output reqReady, respValid, out, error
    );
endinterface

// File: rtl/array_heap_free_stack.sv
// LIFO of released array numbers; the top entry is always visible.
module array_heap_free_stack #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_top,
    output logic             o_empty,
    output logic             o_full
);
    localparam int PW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_cnt;
    logic [IW-1:0]    w_topi;

    assign o_empty = (r_cnt == '0);
    assign o_full  = (r_cnt == PW'(DEPTH));
    assign w_topi  = IW'(r_cnt - PW'(1));
    assign o_top   = r_mem[w_topi];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_push && !o_full) begin
            r_cnt <= r_cnt + PW'(1);
        end else if (i_pop && !o_empty) begin
            r_cnt <= r_cnt - PW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (i_push && !o_full && !i_clear) begin
            r_mem[IW'(r_cnt)] <= i_din;
        end
    end
endmodule

// File: rtl/array_heap.sv
// Array heap: fixed-size arrays with allocation, bounds checks and
// multi-cycle scans, served one request at a time over valid/ready.
module array_heap
    import array_heap_pkg::*;
#(
    parameter int ADDRESS_BITS = 8,
    parameter int INDEX_BITS   = 3,
    parameter int DATA_BITS    = 16
) (
    input  logic        clock,
    input  logic        reset,
    array_heap_if.slave bus
);
    localparam int ARRAYS = 1 << ADDRESS_BITS;
    localparam int LEN    = 1 << INDEX_BITS;
    localparam int SW     = INDEX_BITS + 1;
    localparam int FW     = ADDRESS_BITS + 1;
    localparam int MW     = ADDRESS_BITS + INDEX_BITS;

    state_t r_state, w_next;
    logic   r_live;

    logic [7:0]              r_act;
    logic [ADDRESS_BITS-1:0] r_arr;
    logic [DATA_BITS-1:0]    r_in;
    logic [SW-1:0]           r_sidx;
    logic [DATA_BITS-1:0]    r_scnt;
    logic [ADDRESS_BITS-1:0] r_wptr;

    logic [SW-1:0]        r_size [ARRAYS];
    logic [ARRAYS-1:0]    r_alloc;
    logic [FW-1:0]        r_fresh;
    logic [DATA_BITS-1:0] r_out;
    logic [31:0]          r_err;
    logic [DATA_BITS-1:0] r_mem [ARRAYS*LEN];

    logic                    w_acc;
    logic [SW-1:0]           w_sz;
    logic                    w_isal, w_idx_ok;
    logic [DATA_BITS-1:0]    w_elem, w_lastel;
    logic [INDEX_BITS-1:0]   w_szm1;
    logic [31:0]             w_err;
    logic [DATA_BITS-1:0]    w_res, w_wdata;
    logic [MW-1:0]           w_waddr;
    logic                    w_we, w_szwe, w_aset, w_aclr;
    logic [SW-1:0]           w_sznew;
    logic [ADDRESS_BITS-1:0] w_tgt, w_ftop;
    logic                    w_push, w_pop, w_finc, w_clr;
    logic                    w_fempty, w_ffull;
    logic                    w_scan, w_sweep;

    logic [SW-1:0]        w_ssz;
    logic [DATA_BITS-1:0] w_sel, w_scnt_n, w_sres;
    logic                 w_sin, w_hit, w_shit, w_sdone;

    assign w_acc         = bus.reqValid && bus.reqReady;
    assign bus.reqReady  = r_live && (r_state == ST_IDLE);
    assign bus.respValid = (r_state == ST_RESP);
    assign bus.out       = r_out;
    assign bus.error     = r_err;

    assign w_sz     = r_size[bus.array];
    assign w_isal   = r_alloc[bus.array];
    assign w_idx_ok = ({1'b0, bus.index} < w_sz);
    assign w_elem   = r_mem[{bus.array, bus.index}];
    assign w_szm1   = INDEX_BITS'(w_sz - SW'(1));
    assign w_lastel = r_mem[{bus.array, w_szm1}];

    array_heap_free_stack #(
        .DEPTH(ARRAYS),
        .WIDTH(ADDRESS_BITS)
    ) u_free (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (w_clr),
        .i_din   (bus.array),
        .o_top   (w_ftop),
        .o_empty (w_fempty),
        .o_full  (w_ffull)
    );

    // Single-step actions resolve at accept; only effects of clean actions are enabled.
    always_comb begin
        w_err = E_OK;  w_res = '0;
        w_we = 1'b0;   w_waddr = {bus.array, bus.index};
        w_wdata = bus.in;
        w_szwe = 1'b0; w_sznew = '0;
        w_tgt = bus.array;
        w_aset = 1'b0; w_aclr = 1'b0;
        w_push = 1'b0; w_pop = 1'b0;
        w_finc = 1'b0; w_clr = 1'b0;
        w_scan = 1'b0; w_sweep = 1'b0;
        if (w_acc) begin
            if (bus.action == A_RESET) begin
                w_sweep = 1'b1;
                w_clr   = 1'b1;
            end else if (bus.action == A_ALLOC) begin
                if (!w_fempty) begin
                    w_pop = 1'b1;
                    w_tgt = w_ftop;
                end else if (r_fresh == FW'(ARRAYS)) begin
                    w_err = E_NOSPACE;
                end else begin
                    w_finc = 1'b1;
                    w_tgt  = r_fresh[ADDRESS_BITS-1:0];
                end
                if (w_err == E_OK) begin
                    w_aset = 1'b1;
                    w_szwe = 1'b1;
                    w_res  = DATA_BITS'(w_tgt);
                end
            end else if (!is_known(bus.action)) begin
                w_err = E_ACTION;
            end else if (bus.action == A_FREE) begin
                if (!w_isal) begin
                    w_err = E_DFREE;
                end else begin
                    w_aclr = 1'b1;
                    w_szwe = 1'b1;
                    w_push = !w_ffull;
                end
            end else if (!w_isal) begin
                w_err = E_UNALLOC;
            end else if (is_scan(bus.action)) begin
                w_scan = 1'b1;
            end else begin
                case (bus.action)
                    A_WRITE: begin
                        if (!w_idx_ok) w_err = E_INDEX;
                        else           w_we  = 1'b1;
                    end
                    A_READ: begin
                        if (!w_idx_ok) w_err = E_INDEX;
                        else           w_res = w_elem;
                    end
                    A_SIZE: w_res = DATA_BITS'(w_sz);
                    A_INC, A_PUSH: begin
                        if (w_sz == SW'(LEN)) begin
                            w_err = E_FULL;
                        end else begin
                            w_szwe  = 1'b1;
                            w_sznew = w_sz + SW'(1);
                            w_we    = (bus.action == A_PUSH);
                            w_waddr = {bus.array, w_sz[INDEX_BITS-1:0]};
                        end
                    end
                    A_DEC, A_POP: begin
                        if (w_sz == '0) begin
                            w_err = E_EMPTY;
                        end else begin
                            w_szwe  = 1'b1;
                            w_sznew = w_sz - SW'(1);
                            if (bus.action == A_POP) w_res = w_lastel;
                        end
                    end
                    A_RESIZE: begin
                        if (bus.in > DATA_BITS'(LEN)) begin
                            w_err = E_RESIZE;
                        end else begin
                            w_szwe  = 1'b1;
                            w_sznew = SW'(bus.in);
                        end
                    end
                    A_ADD, A_ADDAFTER, A_SUB, A_SUBAFTER: begin
                        if (!w_idx_ok) begin
                            w_err = E_INDEX;
                        end else begin
                            w_we = 1'b1;
                            if (bus.action == A_ADD || bus.action == A_ADDAFTER)
                                w_wdata = w_elem + bus.in;
                            else
                                w_wdata = w_elem - bus.in;
                            if (bus.action == A_ADD || bus.action == A_SUB)
                                w_res = w_wdata;
                            else
                                w_res = w_elem;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign w_ssz = r_size[r_arr];
    assign w_sel = r_mem[{r_arr, r_sidx[INDEX_BITS-1:0]}];
    assign w_sin = (r_sidx < w_ssz);

    always_comb begin
        case (r_act)
            A_INDEX: w_hit = (w_sel == r_in);
            A_LESS:  w_hit = (w_sel < r_in);
            default: w_hit = (w_sel > r_in);
        endcase
    end

    assign w_shit   = w_sin && w_hit;
    assign w_scnt_n = r_scnt + DATA_BITS'(w_shit);
    assign w_sdone  = ((r_sidx + SW'(1)) >= w_ssz) ||
                      ((r_act == A_INDEX) && w_shit);

    always_comb begin
        w_sres = w_scnt_n;
        if (r_act == A_INDEX) begin
            w_sres = w_shit ? DATA_BITS'(r_sidx) + DATA_BITS'(1) : '0;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_sweep)     w_next = ST_SWEEP;
                else if (w_scan) w_next = ST_SCAN;
                else if (w_acc)  w_next = ST_RESP;
            end
            ST_SCAN:  if (w_sdone) w_next = ST_RESP;
            ST_SWEEP: if (r_wptr == '1) w_next = ST_RESP;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_live  <= 1'b0;
            r_act   <= '0;
            r_arr   <= '0;
            r_in    <= '0;
            r_sidx  <= '0;
            r_scnt  <= '0;
            r_wptr  <= '0;
            r_alloc <= '0;
            r_fresh <= '0;
            r_out   <= '0;
            r_err   <= E_OK;
            for (int i = 0; i < ARRAYS; i++) r_size[i] <= '0;
        end else begin
            r_live <= 1'b1;
            case (r_state)
                ST_IDLE: if (w_acc) begin
                    r_act  <= bus.action;
                    r_arr  <= bus.array;
                    r_in   <= bus.in;
                    r_sidx <= '0;
                    r_scnt <= '0;
                    r_wptr <= '0;
                    if (!w_scan && !w_sweep) begin
                        r_out <= w_res;
                        r_err <= w_err;
                    end
                    if (w_szwe) r_size[w_tgt]  <= w_sznew;
                    if (w_aset) r_alloc[w_tgt] <= 1'b1;
                    if (w_aclr) r_alloc[w_tgt] <= 1'b0;
                    if (w_finc) r_fresh <= r_fresh + FW'(1);
                    if (w_clr)  r_fresh <= '0;
                end
                ST_SCAN: begin
                    r_sidx <= r_sidx + SW'(1);
                    r_scnt <= w_scnt_n;
                    if (w_sdone) begin
                        r_out <= w_sres;
                        r_err <= E_OK;
                    end
                end
                ST_SWEEP: begin
                    r_size[r_wptr]  <= '0;
                    r_alloc[r_wptr] <= 1'b0;
                    r_wptr          <= r_wptr + ADDRESS_BITS'(1);
                    if (r_wptr == '1) begin
                        r_out <= '0;
                        r_err <= E_OK;
                    end
                end
                default: ;
            endcase
        end
    end

    // Element storage is never cleared; stale words stay behind the size bound.
    always_ff @(posedge clock) begin
        if (w_we) r_mem[w_waddr] <= w_wdata;
    end
endmodule

// File: tb/tb_array_heap.sv
// Randomized scoreboard bench for array_heap against a behavioural model.
module tb_array_heap;
    localparam int AB = 2;
    localparam int IB = 1;
    localparam int DB = 12;
    localparam int NA = 1 << AB;
    localparam int LEN = 1 << IB;
    localparam int DMOD = 1 << DB;

    localparam int RESET = 1, WRITE = 2, READ = 3, SIZE = 4;
    localparam int INC = 5, DEC = 6, INDEX = 7, LESS = 8;
    localparam int GREATER = 9, PUSH = 14, POP = 15;
    localparam int RESIZE = 17, ALLOC = 18, FREE = 19;
    localparam int ADD = 20, ADDAFTER = 21, SUB = 22;
    localparam int SUBAFTER = 23;

    typedef struct {
        int     out;
        int     err;
        longint due;
        int     act;
        int     arr;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    array_heap_if #(.ADDRESS_BITS(AB), .INDEX_BITS(IB), .DATA_BITS(DB)) bus ();

    array_heap #(
        .ADDRESS_BITS(AB),
        .INDEX_BITS  (IB),
        .DATA_BITS   (DB)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    exp_t        sb[$];
    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    longint      cyc = 0;

    int m_size [NA];
    bit m_alloc[NA];
    int m_mem  [NA][LEN];
    int m_free [$];
    int m_fresh;

    int acts[17] = '{WRITE, READ, SIZE, INC, DEC, INDEX, LESS,
                     GREATER, PUSH, POP, RESIZE, ALLOC, FREE,
                     ADD, ADDAFTER, SUB, SUBAFTER};
    int bad_acts[6] = '{10, 11, 13, 16, 24, 30};

    always @(posedge clock) cyc++;

    function automatic bit known(input int a);
        return (a >= 1 && a <= 9) || a == 14 || a == 15 ||
               (a >= 17 && a <= 23);
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NA; i++) begin
            m_size[i]  = 0;
            m_alloc[i] = 0;
        end
        m_free.delete();
        m_fresh = 0;
    endfunction

    function automatic void model(input int a, input int arr,
                                  input int idx, input int din,
                                  output int out, output int err,
                                  output int lat);
        int m;
        int old;
        out = 0; err = 0; lat = 1; m = 0;
        if (a == RESET) begin
            model_clear();
            lat = NA + 1;
            return;
        end
        if (a == ALLOC) begin
            if (m_free.size() > 0) begin
                out = m_free.pop_back();
            end else if (m_fresh == NA) begin
                err = 5;
                return;
            end else begin
                out = m_fresh;
                m_fresh++;
            end
            m_alloc[out] = 1;
            m_size[out]  = 0;
            return;
        end
        if (!known(a)) begin err = 8; return; end
        if (a == FREE) begin
            if (!m_alloc[arr]) begin err = 6; return; end
            m_alloc[arr] = 0;
            m_size[arr]  = 0;
            m_free.push_back(arr);
            return;
        end
        if (!m_alloc[arr]) begin err = 1; return; end
        case (a)
            WRITE: if (idx >= m_size[arr]) err = 2;
                   else m_mem[arr][idx] = din;
            READ:  if (idx >= m_size[arr]) err = 2;
                   else out = m_mem[arr][idx];
            SIZE:  out = m_size[arr];
            INC, PUSH: begin
                if (m_size[arr] == LEN) err = 3;
                else begin
                    if (a == PUSH) m_mem[arr][m_size[arr]] = din;
                    m_size[arr]++;
                end
            end
            DEC, POP: begin
                if (m_size[arr] == 0) err = 4;
                else begin
                    if (a == POP) out = m_mem[arr][m_size[arr]-1];
                    m_size[arr]--;
                end
            end
            RESIZE: if (din > LEN) err = 7;
                    else m_size[arr] = din;
            ADD, ADDAFTER, SUB, SUBAFTER: begin
                if (idx >= m_size[arr]) err = 2;
                else begin
                    old = m_mem[arr][idx];
                    if (a == ADD || a == ADDAFTER)
                        m_mem[arr][idx] = (old + din) % DMOD;
                    else
                        m_mem[arr][idx] = (old - din + DMOD) % DMOD;
                    out = (a == ADD || a == SUB) ? m_mem[arr][idx] : old;
                end
            end
            INDEX: begin
                m = m_size[arr];
                for (int p = 0; p < m_size[arr]; p++) begin
                    if (m_mem[arr][p] == din) begin
                        out = p + 1;
                        m = p + 1;
                        break;
                    end
                end
                lat = (m < 1 ? 1 : m) + 1;
            end
            LESS, GREATER: begin
                for (int p = 0; p < m_size[arr]; p++) begin
                    if (a == LESS && m_mem[arr][p] < din) out++;
                    if (a == GREATER && m_mem[arr][p] > din) out++;
                end
                m = m_size[arr];
                lat = (m < 1 ? 1 : m) + 1;
            end
            default: ;
        endcase
    endfunction

    task automatic summary();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    endtask

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Monitor: every response is matched against the oldest expectation.
    always @(negedge clock) begin
        exp_t e;
        if (reset && bus.respValid) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_resp: got out=%0d err=%0d, want none",
                         bus.out, bus.error);
            end else begin
                e = sb.pop_front();
                if (bus.out !== DB'(e.out) || bus.error !== e.err ||
                    cyc != e.due) begin
                    n_bad++;
                    $display("FAIL resp act%0d a%0d: got out=%0d err=%0d cyc=%0d, want out=%0d err=%0d cyc=%0d",
                             e.act, e.arr, bus.out, bus.error, cyc,
                             e.out, e.err, e.due);
                end
            end
        end
    end

    task automatic issue(input int a, input int arr,
                         input int idx, input int din);
        int   o, e, l, t;
        exp_t x;
        t = 0;
        @(negedge clock);
        while (!bus.reqReady) begin
            bus.reqValid = 1'b1;
            bus.action   = 8'($urandom_range(1, 23));
            bus.array    = AB'($urandom);
            bus.index    = IB'($urandom);
            bus.in       = DB'($urandom);
            t++;
            if (t > NA * 4 + 50) begin
                n_vec++;
                n_bad++;
                $display("FAIL ready_timeout: got reqReady=0, want 1");
                summary();
                $finish;
            end
            @(negedge clock);
        end
        bus.reqValid = 1'b1;
        bus.action   = 8'(a);
        bus.array    = AB'(arr);
        bus.index    = IB'(idx);
        bus.in       = DB'(din);
        model(a, arr, idx, din, o, e, l);
        x.out = o; x.err = e; x.due = cyc + l;
        x.act = a; x.arr = arr;
        sb.push_back(x);
        @(posedge clock);
        #1;
        bus.reqValid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clock);
            t++;
        end
        #1;
        if (sb.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        n_vec++;
        n_bad++;
        $display("FAIL watchdog: got no finish, want finish");
        summary();
        $finish;
    end

    initial begin
        int a, arr, din;
        bus.reqValid = 1'b0;
        bus.action   = '0;
        bus.array    = '0;
        bus.index    = '0;
        bus.in       = '0;
        model_clear();
        for (int i = 0; i < NA; i++)
            for (int j = 0; j < LEN; j++) m_mem[i][j] = 0;

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_ready", 32'(bus.reqReady), 0);
        chk("rst_resp", 32'(bus.respValid), 0);
        chk("rst_out", 32'(bus.out), 0);
        chk("rst_err", bus.error, 0);
        reset = 1'b1;
        #1;
        chk("ready_at_release", 32'(bus.reqReady), 0);
        @(negedge clock);
        chk("ready_after_clk", 32'(bus.reqReady), 1);

        // Alloc all arrays, then the fifth fails; fill storage for later resizes.
        for (int i = 0; i < NA; i++) issue(ALLOC, 0, 0, 0);
        issue(ALLOC, 0, 0, 0);
        for (int i = 0; i < NA; i++) begin
            issue(RESIZE, i, 0, LEN);
            for (int j = 0; j < LEN; j++)
                issue(WRITE, i, j, $urandom_range(0, 15));
        end
        issue(RESET, 0, 0, 0);

        issue(ALLOC, 0, 0, 0);
        issue(PUSH, 0, 0, 5);
        issue(PUSH, 0, 0, 7);
        issue(PUSH, 0, 0, 9);
        issue(POP, 0, 0, 0);
        issue(SIZE, 0, 0, 0);
        issue(WRITE, 0, 0, 3);
        issue(PUSH, 0, 0, 9);
        issue(GREATER, 0, 0, 4);
        issue(INDEX, 0, 0, 9);
        issue(LESS, 0, 0, 1);
        issue(WRITE, 0, 0, 4095);
        issue(ADD, 0, 0, 2);
        issue(ADDAFTER, 0, 0, 1);
        issue(READ, 0, 0, 0);
        issue(SUB, 0, 1, 10);
        issue(READ, 0, 2 % LEN, 0);
        issue(RESIZE, 0, 0, LEN + 1);
        issue(ALLOC, 0, 0, 0);
        issue(ALLOC, 0, 0, 0);
        issue(FREE, 1, 0, 0);
        issue(FREE, 1, 0, 0);
        issue(ALLOC, 0, 0, 0);
        issue(READ, 3, 0, 0);
        issue(INDEX, 2, 0, 0);
        issue(DEC, 2, 0, 0);
        issue(READ, 2, 0, 0);
        issue(16, 0, 0, 0);
        drain();

        for (int n = 0; n < 300; n++) begin
            arr = $urandom_range(0, NA - 1);
            din = ($urandom_range(0, 7) == 0) ? $urandom_range(0, DMOD - 1)
                                              : $urandom_range(0, 12);
            a = acts[$urandom_range(0, 16)];
            if (a == RESIZE) din = $urandom_range(0, LEN + 1);
            if ($urandom_range(0, 49) == 0) a = RESET;
            if ($urandom_range(0, 29) == 0 && m_alloc[arr])
                a = bad_acts[$urandom_range(0, 5)];
            issue(a, arr, $urandom_range(0, LEN - 1), din);
        end
        drain();

        // Reset asserted mid-scan must abort it silently.
        issue(RESET, 0, 0, 0);
        issue(ALLOC, 0, 0, 0);
        issue(RESIZE, 0, 0, LEN);
        drain();
        @(negedge clock);
        chk("ready_before_scan", 32'(bus.reqReady), 1);
        bus.reqValid = 1'b1;
        bus.action   = 8'(GREATER);
        bus.array    = '0;
        bus.index    = '0;
        bus.in       = '0;
        @(posedge clock);
        #1;
        bus.reqValid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("abort_resp", 32'(bus.respValid), 0);
        chk("abort_ready", 32'(bus.reqReady), 0);
        chk("abort_out", 32'(bus.out), 0);
        chk("abort_err", bus.error, 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        model_clear();
        @(negedge clock);
        chk("ready_after_abort", 32'(bus.reqReady), 1);
        for (int i = 0; i < NA; i++) issue(SIZE, i, 0, 0);
        issue(ALLOC, 0, 0, 0);
        issue(SIZE, 0, 0, 0);
        drain();
        repeat (3) @(negedge clock);

        summary();
        $finish;
    end
endmodule
